timer_cnt_cmp: RTL and testbench
================================

# timer_cnt_cmp

Parametrised timer counter with prescaler, debug halt, per-word software writes and NUM_CH compare channels with sticky interrupt status. It replaces the fixed 64-bit, two-word timer counter in the timer IP. Register-interface decode (word write selects, compare values, interrupt enable/clear) sits upstream. irq goes to the interrupt controller.

## Interface
- NUM_WORDS, 2: number of 32-bit counter words; counter width CW = 32*NUM_WORDS, range 1..4
- NUM_CH, 4: number of compare channels, range 1..8
- DEFAULT_CNT, 0: counter value after reset and after rst_cnt (CW bits)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cnt_en  in  1  counting enable
- rst_cnt  in  1  synchronous counter/prescaler clear
- div_en  in  1  prescaler enable
- div_val  in  4  prescaler exponent, tick period 2^div_val cycles; values >8 treated as 8
- halt_req  in  1  debug halt request
- wr_sel  in  NUM_WORDS  one-hot-or-zero word write select
- wr_data  in  32  word write data
- cmp_val  in  NUM_CH*CW  compare values, channel k at bits [k*CW +: CW]
- int_en  in  NUM_CH  interrupt enables
- int_clr  in  NUM_CH  status clear pulses
- cnt  out  CW  counter value (register)
- int_st  out  NUM_CH  sticky compare status
- ovf_st  out  1  sticky overflow status, cleared by rst_cnt
- halt_ack  out  1  registered halt indication
- irq  out  1  OR of int_st & int_en

## Operation
- Reset (rst_n=0):
  - cnt=DEFAULT_CNT.
  - Prescaler count div_cnt (8 bits) = 0.
  - int_st=0, ovf_st=0, halt_ack=0.
- halt_ack <= halt_req every cycle. While halt_ack=1:
  - No ticks and div_cnt holds.
  - Writes and rst_cnt still act.
- Tick generation, with run = cnt_en & !halt_ack:
  - div_en=0: tick=run.
  - div_en=1: div_cnt increments while run. tick=run & (div_cnt == 2^div_val−1), and div_cnt wraps to 0 on tick.
  - div_cnt cleared when cnt_en=0, div_en=0 or rst_cnt=1.
- Next value per word i, in priority order:
  1. rst_cnt: DEFAULT_CNT word i.
  2. wr_sel[i]: wr_data.
  3. tick: word i of (cnt+1), full-width carry.
  4. Otherwise hold.
- Words not written take the incremented value in the same cycle. Carry into a written word is lost.
- Overflow: a tick with cnt = all-ones (and no rst_cnt/write to any word) gives cnt=0 and sets ovf_st. rst_cnt clears ovf_st.
- Compare channel k:
  - Sets int_st[k] when an update (tick, any write, or rst_cnt) produces cnt_next == cmp_val[k].
  - A held counter never re-sets int_st[k].
  - int_clr[k] clears int_st[k]; a simultaneous set wins.
  - int_st sets regardless of int_en.
- irq combinational from int_st and int_en registers/inputs; no other output is combinational.

## Timing
- Counter, int_st and ovf_st update on the same clk edge. int_st[k] and the matching cnt become visible together.
- Tick effect visible 1 cycle after the tick condition. With div_en=1 the first tick after enable comes 2^div_val cycles after cnt_en rises.
- halt_req to freeze latency: 1 cycle. The cycle in which halt_req first rises can still tick.
- A div_val change takes effect immediately. If div_cnt already exceeds the new terminal value, it counts up to 255, wraps, then reaches the terminal.
- Reset mid-operation: all state returns to reset values asynchronously. The first tick requires a full prescaler period.

## Test plan
- Reset and run: NUM_WORDS=2, rst_n low, then cnt_en=1, div_en=0 for 10 cycles -> cnt=0 during reset, cnt=10 after 10 cycles, int_st=0, irq=0.
- Prescaler: div_en=1, div_val=2, cnt_en=1 for 16 cycles -> cnt increments every 4th cycle, cnt=4. div_val=12 -> period 256.
- Carry with write: cnt=0x0000_0000_FFFF_FFFF, tick plus wr_sel=2'b10, wr_data=5 -> cnt=0x0000_0005_0000_0000. Same start, tick plus rst_cnt -> cnt=0, ovf_st=0.
- Overflow: write both words to 0xFFFF_FFFF, one tick -> cnt=0, ovf_st=1. ovf_st holds until rst_cnt.
- Compare: cmp_val[1]=7, int_en=4'b0010, count from 0 -> int_st[1]=1 and irq=1 with cnt=7. Halt at 7 -> no re-set after int_clr[1]. int_clr with a simultaneous match -> int_st stays 1.
- Halt: halt_req=1 while counting -> halt_ack next cycle, cnt frozen, a write of word 0 still lands. Release -> counting resumes.

Source files
------------

// File: rtl/timer_cnt_cmp_if.sv
// Bus bundle for timer_cnt_cmp: counter control, word writes, compare
// channels and status outputs. clk/rst_n stay outside the bundle.
interface timer_cnt_cmp_if #(
    parameter int NUM_WORDS = 2,
    parameter int NUM_CH    = 4
);
    localparam int CW = 32 * NUM_WORDS;

    logic                   cnt_en;
    logic                   rst_cnt;
    logic                   div_en;
    logic [3:0]             div_val;
    logic                   halt_req;
    logic [NUM_WORDS-1:0]   wr_sel;
    logic [31:0]            wr_data;
    logic [NUM_CH*CW-1:0]   cmp_val;
    logic [NUM_CH-1:0]      int_en;
    logic [NUM_CH-1:0]      int_clr;
    logic [CW-1:0]          cnt;
    logic [NUM_CH-1:0]      int_st;
    logic                   ovf_st;
    logic                   halt_ack;
    logic                   irq;

    modport master (
        output cnt_en, rst_cnt, div_en, div_val, halt_req, wr_sel, wr_data,
               cmp_val, int_en, int_clr,
        input  cnt, int_st, ovf_st, halt_ack, irq
    );

    modport slave (
        input  cnt_en, rst_cnt, div_en, div_val, halt_req, wr_sel, wr_data,
               cmp_val, int_en, int_clr,
        output cnt, int_st, ovf_st, halt_ack, irq
    );
endinterface

// File: rtl/timer_cnt_cmp.sv
// Parametrised multi-word timer counter with power-of-two prescaler, debug
// halt, per-word software writes and sticky compare/overflow status.
module timer_cnt_cmp #(
    parameter int                     NUM_WORDS   = 2,
    parameter int                     NUM_CH      = 4,
    parameter logic [32*NUM_WORDS-1:0] DEFAULT_CNT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_cnt_cmp_if.slave   bus
);
    localparam int CW = 32 * NUM_WORDS;

    // Terminal prescaler count for a given exponent; exponents above 8 clamp to 8.
    function automatic logic [7:0] div_terminal(input logic [3:0] dv);
        logic [3:0] e;
        logic [8:0] p;
        e = (dv > 4'd8) ? 4'd8 : dv;
        p = (9'd1 << e) - 9'd1;
        return p[7:0];
    endfunction

    logic [CW-1:0]     cnt_r;
    logic [7:0]        div_cnt_r;
    logic [NUM_CH-1:0] int_st_r;
    logic              ovf_st_r;
    logic              halt_ack_r;

    logic              run_s;
    logic              tick_s;
    logic              update_s;
    logic [CW-1:0]     cnt_inc_s;
    logic [CW-1:0]     cnt_next_s;
    logic [7:0]        div_cnt_next_s;
    logic [NUM_CH-1:0] int_st_next_s;
    logic              ovf_st_next_s;

    assign run_s     = bus.cnt_en & ~halt_ack_r;
    assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    assign update_s  = tick_s | (|bus.wr_sel) | bus.rst_cnt;

    // Tick decode and prescaler next state.
    always_comb begin
        tick_s         = 1'b0;
        div_cnt_next_s = div_cnt_r;
        if (!bus.cnt_en || !bus.div_en || bus.rst_cnt) begin
            tick_s         = bus.div_en ? 1'b0 : (run_s & ~bus.rst_cnt) | (run_s & bus.rst_cnt);
            div_cnt_next_s = 8'd0;
        end else if (!run_s) begin
            tick_s         = 1'b0;
            div_cnt_next_s = div_cnt_r;
        end else if (div_cnt_r == div_terminal(bus.div_val)) begin
            tick_s         = 1'b1;
            div_cnt_next_s = 8'd0;
        end else begin
            tick_s         = 1'b0;
            div_cnt_next_s = div_cnt_r + 8'd1;
        end
    end

    // Per-word counter next value: clear, then write, then increment, else hold.
    always_comb begin
        cnt_next_s = cnt_r;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (bus.rst_cnt) begin
                cnt_next_s[i*32 +: 32] = DEFAULT_CNT[i*32 +: 32];
            end else if (bus.wr_sel[i]) begin
                cnt_next_s[i*32 +: 32] = bus.wr_data;
            end else if (tick_s) begin
                cnt_next_s[i*32 +: 32] = cnt_inc_s[i*32 +: 32];
            end else begin
                cnt_next_s[i*32 +: 32] = cnt_r[i*32 +: 32];
            end
        end
    end

    // Sticky status next state; a compare hit outranks a clear in the same cycle.
    always_comb begin
        int_st_next_s = int_st_r;
        for (int k = 0; k < NUM_CH; k++) begin
            if (update_s && (cnt_next_s == bus.cmp_val[k*CW +: CW])) begin
                int_st_next_s[k] = 1'b1;
            end else if (bus.int_clr[k]) begin
                int_st_next_s[k] = 1'b0;
            end else begin
                int_st_next_s[k] = int_st_r[k];
            end
        end
        if (bus.rst_cnt) begin
            ovf_st_next_s = 1'b0;
        end else if (tick_s && (&cnt_r) && (bus.wr_sel == '0)) begin
            ovf_st_next_s = 1'b1;
        end else begin
            ovf_st_next_s = ovf_st_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= DEFAULT_CNT;
            div_cnt_r  <= 8'd0;
            int_st_r   <= '0;
            ovf_st_r   <= 1'b0;
            halt_ack_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            div_cnt_r  <= div_cnt_next_s;
            int_st_r   <= int_st_next_s;
            ovf_st_r   <= ovf_st_next_s;
            halt_ack_r <= bus.halt_req;
        end
    end

    assign bus.cnt      = cnt_r;
    assign bus.int_st   = int_st_r;
    assign bus.ovf_st   = ovf_st_r;
    assign bus.halt_ack = halt_ack_r;
    assign bus.irq      = |(int_st_r & bus.int_en);
endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Directed self-checking bench for timer_cnt_cmp (NUM_WORDS=2, NUM_CH=4).
module tb_timer_cnt_cmp;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    timer_cnt_cmp_if #(.NUM_WORDS(2), .NUM_CH(4)) bus ();

    timer_cnt_cmp #(.NUM_WORDS(2), .NUM_CH(4), .DEFAULT_CNT(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.cnt_en   = 1'b1;
        bus.rst_cnt  = 1'b0;
        bus.div_en   = 1'b0;
        bus.div_val  = 4'd0;
        bus.halt_req = 1'b0;
        bus.wr_sel   = 2'b00;
        bus.wr_data  = 32'd0;
        bus.cmp_val  = {4{64'hDEAD_BEEF_0000_0000}};
        bus.int_en   = 4'b0000;
        bus.int_clr  = 4'b0000;
        step(2);
        chk64("reset_cnt", bus.cnt, 64'd0);
        chk64("reset_int_st", {60'd0, bus.int_st}, 64'd0);
        chk64("reset_ovf", {63'd0, bus.ovf_st}, 64'd0);
        chk64("reset_halt_ack", {63'd0, bus.halt_ack}, 64'd0);
        rst_n = 1'b1;
        step(10);
        chk64("run_cnt10", bus.cnt, 64'd10);
        chk64("run_int_st", {60'd0, bus.int_st}, 64'd0);
        chk64("run_irq", {63'd0, bus.irq}, 64'd0);
    endtask

    task automatic test_prescaler;
        bus.rst_cnt = 1'b1;
        step(1);
        bus.rst_cnt = 1'b0;
        bus.div_en  = 1'b1;
        bus.div_val = 4'd2;
        step(3);
        chk64("div4_before_tick", bus.cnt, 64'd0);
        step(1);
        chk64("div4_first_tick", bus.cnt, 64'd1);
        step(12);
        chk64("div4_16cyc", bus.cnt, 64'd4);
        bus.div_val = 4'd12;
        bus.rst_cnt = 1'b1;
        step(1);
        bus.rst_cnt = 1'b0;
        step(255);
        chk64("div256_before_tick", bus.cnt, 64'd0);
        step(1);
        chk64("div256_tick", bus.cnt, 64'd1);
        bus.div_en = 1'b0;
    endtask

    task automatic load(input logic [63:0] v);
        bus.cnt_en  = 1'b0;
        bus.wr_sel  = 2'b01;
        bus.wr_data = v[31:0];
        step(1);
        bus.wr_sel  = 2'b10;
        bus.wr_data = v[63:32];
        step(1);
        bus.wr_sel  = 2'b00;
    endtask

    task automatic test_carry_write;
        load(64'h0000_0000_FFFF_FFFF);
        chk64("load_value", bus.cnt, 64'h0000_0000_FFFF_FFFF);
        bus.cnt_en  = 1'b1;
        bus.wr_sel  = 2'b10;
        bus.wr_data = 32'd5;
        step(1);
        bus.cnt_en  = 1'b0;
        bus.wr_sel  = 2'b00;
        chk64("carry_lost_write", bus.cnt, 64'h0000_0005_0000_0000);
        chk64("carry_no_ovf", {63'd0, bus.ovf_st}, 64'd0);
        load(64'h0000_0000_FFFF_FFFF);
        bus.cnt_en  = 1'b1;
        bus.rst_cnt = 1'b1;
        step(1);
        bus.cnt_en  = 1'b0;
        bus.rst_cnt = 1'b0;
        chk64("tick_rst_cnt", bus.cnt, 64'd0);
        chk64("tick_rst_ovf", {63'd0, bus.ovf_st}, 64'd0);
    endtask

    task automatic test_overflow;
        load(64'hFFFF_FFFF_FFFF_FFFF);
        bus.cnt_en = 1'b1;
        step(1);
        chk64("ovf_cnt", bus.cnt, 64'd0);
        chk64("ovf_set", {63'd0, bus.ovf_st}, 64'd1);
        step(3);
        chk64("ovf_cnt_after", bus.cnt, 64'd3);
        chk64("ovf_sticky", {63'd0, bus.ovf_st}, 64'd1);
        bus.rst_cnt = 1'b1;
        step(1);
        bus.rst_cnt = 1'b0;
        chk64("ovf_cleared", {63'd0, bus.ovf_st}, 64'd0);
    endtask

    task automatic test_compare;
        bus.cmp_val[1*64 +: 64] = 64'd7;
        bus.int_en  = 4'b0010;
        bus.cnt_en  = 1'b1;
        bus.rst_cnt = 1'b1;
        bus.int_clr = 4'b1111;
        step(1);
        bus.rst_cnt = 1'b0;
        bus.int_clr = 4'b0000;
        step(6);
        chk64("cmp_cnt6", bus.cnt, 64'd6);
        chk64("cmp_not_yet", {60'd0, bus.int_st}, 64'd0);
        chk64("cmp_irq_low", {63'd0, bus.irq}, 64'd0);
        bus.halt_req = 1'b1;
        step(1);
        chk64("cmp_cnt7", bus.cnt, 64'd7);
        chk64("cmp_hit", {60'd0, bus.int_st}, 64'd2);
        chk64("cmp_irq", {63'd0, bus.irq}, 64'd1);
        bus.int_clr = 4'b0010;
        step(1);
        bus.int_clr = 4'b0000;
        step(2);
        chk64("held_cnt", bus.cnt, 64'd7);
        chk64("held_no_reset", {60'd0, bus.int_st}, 64'd0);
        chk64("held_irq_low", {63'd0, bus.irq}, 64'd0);
        bus.wr_sel  = 2'b01;
        bus.wr_data = 32'd7;
        step(1);
        chk64("write_match", {60'd0, bus.int_st}, 64'd2);
        bus.int_clr = 4'b0010;
        step(1);
        bus.wr_sel  = 2'b00;
        bus.int_clr = 4'b0000;
        chk64("set_beats_clr", {60'd0, bus.int_st}, 64'd2);
    endtask

    task automatic test_halt;
        bus.halt_req = 1'b0;
        bus.int_clr  = 4'b1111;
        bus.rst_cnt  = 1'b1;
        step(1);
        bus.int_clr  = 4'b0000;
        bus.rst_cnt  = 1'b0;
        step(5);
        chk64("halt_pre_cnt", bus.cnt, 64'd5);
        bus.halt_req = 1'b1;
        step(1);
        chk64("halt_ack", {63'd0, bus.halt_ack}, 64'd1);
        chk64("halt_last_tick", bus.cnt, 64'd6);
        step(3);
        chk64("halt_frozen", bus.cnt, 64'd6);
        bus.wr_sel  = 2'b01;
        bus.wr_data = 32'd100;
        step(1);
        bus.wr_sel  = 2'b00;
        chk64("halt_write", bus.cnt, 64'd100);
        bus.halt_req = 1'b0;
        step(1);
        chk64("release_cnt", bus.cnt, 64'd100);
        chk64("release_ack", {63'd0, bus.halt_ack}, 64'd0);
        step(2);
        chk64("resume_cnt", bus.cnt, 64'd102);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_prescaler();
        test_carry_write();
        test_overflow();
        test_compare();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
